// File: rtl/seq_checker.sv
// Receive-side checker for the 3-bit T-flip-flop sequence 000-001-011-101-111.
// Define SEQ_CHECK_RESYNC_EN to re-anchor expected on legal mismatches while locked.
module seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       data_in,
  input  logic             valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       expected
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t             r_state;
  logic [3:0]         r_match_cnt;
  logic [3:0]         r_err_run;
  logic               r_locked;
  logic               r_err_pulse;
  logic [CNT_W-1:0]   r_err_count;
  logic [2:0]         r_expected;

  logic [2:0]         w_next_data;
  logic [2:0]         w_next_exp;
  logic               w_legal;
  logic               w_match;

  function automatic logic [2:0] f_next(input logic [2:0] c);
    case (c)
      3'b000:  f_next = 3'b001;
      3'b001:  f_next = 3'b011;
      3'b011:  f_next = 3'b101;
      3'b101:  f_next = 3'b111;
      default: f_next = 3'b000;
    endcase
  endfunction

  assign w_legal     = (data_in == 3'b000) || (data_in == 3'b001) || (data_in == 3'b011) ||
                       (data_in == 3'b101) || (data_in == 3'b111);
  assign w_next_data = f_next(data_in);
  assign w_next_exp  = f_next(r_expected);
  assign w_match     = (data_in == r_expected);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state     <= HUNT;
      r_match_cnt <= 4'd0;
      r_err_run   <= 4'd0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_expected  <= 3'b000;
    end else begin
      r_err_pulse <= 1'b0;
      if (valid) begin
        case (r_state)
          HUNT: begin
            if (r_match_cnt == 4'd0) begin
              if (w_legal) begin
                r_expected  <= w_next_data;
                r_match_cnt <= 4'd1;
              end
            end else if (w_match) begin
              r_expected <= w_next_data;
              if (r_match_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_err_run   <= 4'd0;
                r_match_cnt <= 4'd0;
              end else begin
                r_match_cnt <= r_match_cnt + 4'd1;
              end
            end else if (w_legal) begin
              // Re-anchor the hunt on this sample rather than discarding it
              r_match_cnt <= 4'd1;
              r_expected  <= w_next_data;
            end else begin
              r_match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_err_run  <= 4'd0;
              r_expected <= w_next_exp;
            end else begin
              r_err_pulse <= 1'b1;
              if (r_err_count != {CNT_W{1'b1}})
                r_err_count <= r_err_count + 1'b1;
              if (r_err_run + 4'd1 == 4'(LOSS_COUNT)) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_match_cnt <= 4'd0;
                r_err_run   <= 4'd0;
              end else begin
                r_err_run <= r_err_run + 4'd1;
`ifdef SEQ_CHECK_RESYNC_EN
                r_expected <= w_legal ? w_next_data : w_next_exp;
`else
                r_expected <= w_next_exp;
`endif
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
      if (err_clr)
        r_err_count <= '0;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule

// File: tb/tb_seq_checker.sv
// Directed self-checking bench for seq_checker: default instance plus a CNT_W=2 instance.
module tb_seq_checker;

  logic       clk;
  logic       clear;
  logic [2:0] a_data, b_data;
  logic       a_valid, b_valid, a_clr, b_clr;
  logic       a_locked, a_pulse, b_locked, b_pulse;
  logic [7:0] a_count;
  logic [1:0] b_count;
  logic [2:0] a_exp, b_exp;

  int n_tests = 0;
  int n_fail  = 0;

  seq_checker dut_a (
    .clk(clk), .clear(clear), .data_in(a_data), .valid(a_valid), .err_clr(a_clr),
    .locked(a_locked), .err_pulse(a_pulse), .err_count(a_count), .expected(a_exp)
  );

  seq_checker #(.CNT_W(2)) dut_b (
    .clk(clk), .clear(clear), .data_in(b_data), .valid(b_valid), .err_clr(b_clr),
    .locked(b_locked), .err_pulse(b_pulse), .err_count(b_count), .expected(b_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_a(input string tag, input logic lk, input logic ep,
                       input logic [7:0] ec, input logic [2:0] ex);
    chk({tag, ".locked"},    32'(a_locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(a_pulse),  32'(ep));
    chk({tag, ".err_count"}, 32'(a_count),  32'(ec));
    chk({tag, ".expected"},  32'(a_exp),    32'(ex));
  endtask

  task automatic chk_b(input string tag, input logic lk, input logic ep,
                       input logic [1:0] ec, input logic [2:0] ex);
    chk({tag, ".locked"},    32'(b_locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(b_pulse),  32'(ep));
    chk({tag, ".err_count"}, 32'(b_count),  32'(ec));
    chk({tag, ".expected"},  32'(b_exp),    32'(ex));
  endtask

  task automatic step_a(input logic [2:0] d, input logic v, input logic c);
    a_data = d; a_valid = v; a_clr = c;
    b_valid = 1'b0; b_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [2:0] d, input logic v, input logic c);
    b_data = d; b_valid = v; b_clr = c;
    a_valid = 1'b0; a_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    a_data = 3'b000; a_valid = 1'b0; a_clr = 1'b0;
    b_data = 3'b000; b_valid = 1'b0; b_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("in_reset", 1'b0, 1'b0, 8'd0, 3'b000);
    clear = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step_a(3'b011, 1'b0, 1'b0);
      chk_a("idle", 1'b0, 1'b0, 8'd0, 3'b000);
    end

    // Acquire lock on default instance
    step_a(3'b000, 1'b1, 1'b0); chk_a("acq1", 1'b0, 1'b0, 8'd0, 3'b001);
    step_a(3'b001, 1'b1, 1'b0); chk_a("acq2", 1'b0, 1'b0, 8'd0, 3'b011);
    step_a(3'b011, 1'b1, 1'b0); chk_a("acq3", 1'b0, 1'b0, 8'd0, 3'b101);
    step_a(3'b101, 1'b1, 1'b0); chk_a("acq4", 1'b1, 1'b0, 8'd0, 3'b111);
    step_a(3'b111, 1'b1, 1'b0); chk_a("run1", 1'b1, 1'b0, 8'd0, 3'b000);
    step_a(3'b000, 1'b1, 1'b0); chk_a("run2", 1'b1, 1'b0, 8'd0, 3'b001);

    // Illegal code in place of 011 free-runs in both builds
    step_a(3'b001, 1'b1, 1'b0); chk_a("ill0", 1'b1, 1'b0, 8'd0, 3'b011);
    step_a(3'b010, 1'b1, 1'b0); chk_a("ill1", 1'b1, 1'b1, 8'd1, 3'b101);
    step_a(3'b101, 1'b1, 1'b0); chk_a("ill2", 1'b1, 1'b0, 8'd1, 3'b111);
    step_a(3'b111, 1'b1, 1'b0); chk_a("ill3", 1'b1, 1'b0, 8'd1, 3'b000);

    step_a(3'b000, 1'b0, 1'b1); chk_a("errclr", 1'b1, 1'b0, 8'd0, 3'b000);

    // Three wrong legal codes, chosen to be wrong in both builds
    step_a(3'b001, 1'b1, 1'b0); chk("loss1.count", 32'(a_count), 32'd1);
    chk("loss1.pulse", 32'(a_pulse), 32'd1);
    chk("loss1.locked", 32'(a_locked), 32'd1);
    step_a(3'b111, 1'b1, 1'b0); chk("loss2.count", 32'(a_count), 32'd2);
    chk("loss2.locked", 32'(a_locked), 32'd1);
    step_a(3'b101, 1'b1, 1'b0); chk("loss3.count", 32'(a_count), 32'd3);
    chk("loss3.pulse", 32'(a_pulse), 32'd1);
    chk("loss3.locked", 32'(a_locked), 32'd0);

    // Relock needs four fresh in-order samples
    step_a(3'b000, 1'b1, 1'b0); chk_a("rl1", 1'b0, 1'b0, 8'd3, 3'b001);
    step_a(3'b001, 1'b1, 1'b0); chk_a("rl2", 1'b0, 1'b0, 8'd3, 3'b011);
    step_a(3'b011, 1'b1, 1'b0); chk_a("rl3", 1'b0, 1'b0, 8'd3, 3'b101);
    step_a(3'b101, 1'b1, 1'b0); chk_a("rl4", 1'b1, 1'b0, 8'd3, 3'b111);

    // Phase slip: 001 arrives where 011 is expected
    step_a(3'b111, 1'b1, 1'b0); chk_a("ps0a", 1'b1, 1'b0, 8'd3, 3'b000);
    step_a(3'b000, 1'b1, 1'b0); chk_a("ps0b", 1'b1, 1'b0, 8'd3, 3'b001);
    step_a(3'b001, 1'b1, 1'b0); chk_a("ps0c", 1'b1, 1'b0, 8'd3, 3'b011);
`ifdef SEQ_CHECK_RESYNC_EN
    step_a(3'b001, 1'b1, 1'b0); chk_a("ps1", 1'b1, 1'b1, 8'd4, 3'b011);
    step_a(3'b011, 1'b1, 1'b0); chk_a("ps2", 1'b1, 1'b0, 8'd4, 3'b101);
    step_a(3'b101, 1'b1, 1'b0); chk_a("ps3", 1'b1, 1'b0, 8'd4, 3'b111);
`else
    step_a(3'b001, 1'b1, 1'b0); chk_a("ps1", 1'b1, 1'b1, 8'd4, 3'b101);
    step_a(3'b011, 1'b1, 1'b0); chk_a("ps2", 1'b1, 1'b1, 8'd5, 3'b111);
    step_a(3'b101, 1'b1, 1'b0); chk("ps3.locked", 32'(a_locked), 32'd0);
    chk("ps3.count", 32'(a_count), 32'd6);
    chk("ps3.pulse", 32'(a_pulse), 32'd1);
`endif

    // CNT_W=2 instance: lock, then five mismatches interleaved with matches
    step_b(3'b000, 1'b1, 1'b0);
    step_b(3'b001, 1'b1, 1'b0);
    step_b(3'b011, 1'b1, 1'b0);
    step_b(3'b101, 1'b1, 1'b0); chk_b("b_lock", 1'b1, 1'b0, 2'd0, 3'b111);
    step_b(3'b010, 1'b1, 1'b0); chk_b("b_m1", 1'b1, 1'b1, 2'd1, 3'b000);
    step_b(3'b000, 1'b1, 1'b0); chk_b("b_k1", 1'b1, 1'b0, 2'd1, 3'b001);
    step_b(3'b010, 1'b1, 1'b0); chk_b("b_m2", 1'b1, 1'b1, 2'd2, 3'b011);
    step_b(3'b011, 1'b1, 1'b0); chk_b("b_k2", 1'b1, 1'b0, 2'd2, 3'b101);
    step_b(3'b010, 1'b1, 1'b0); chk_b("b_m3", 1'b1, 1'b1, 2'd3, 3'b111);
    step_b(3'b111, 1'b1, 1'b0); chk_b("b_k3", 1'b1, 1'b0, 2'd3, 3'b000);
    step_b(3'b010, 1'b1, 1'b0); chk_b("b_m4", 1'b1, 1'b1, 2'd3, 3'b001);
    step_b(3'b001, 1'b1, 1'b0); chk_b("b_k4", 1'b1, 1'b0, 2'd3, 3'b011);
    step_b(3'b010, 1'b1, 1'b0); chk_b("b_m5", 1'b1, 1'b1, 2'd3, 3'b101);
    step_b(3'b101, 1'b1, 1'b0); chk_b("b_k5", 1'b1, 1'b0, 2'd3, 3'b111);
    step_b(3'b010, 1'b1, 1'b1); chk_b("b_clrmis", 1'b1, 1'b1, 2'd0, 3'b000);
    step_b(3'b000, 1'b1, 1'b0); chk_b("b_k6", 1'b1, 1'b0, 2'd0, 3'b001);
    step_b(3'b010, 1'b1, 1'b0); chk_b("b_m6", 1'b1, 1'b1, 2'd1, 3'b011);

    // Asynchronous clear mid-lock, observed before the next clock edge
    #2 clear = 1'b1;
    #1;
    chk_b("b_async", 1'b0, 1'b0, 2'd0, 3'b000);
    chk_a("a_async", 1'b0, 1'b0, 8'd0, 3'b000);
    @(posedge clk);
    #1 clear = 1'b0;
    step_b(3'b011, 1'b1, 1'b0); chk_b("b_post", 1'b0, 1'b0, 2'd0, 3'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
